dmem_access_ctrl: RTL

- Sequences every data-memory access made by the MEM stage against a variable-latency data memory using a req/ack handshake.
- Shares that memory with a debug/loader port.
- Drives the pipeline stall that freezes PC, IF/ID, ID/EX and EX/MEM until the access completes.
- Sits between the EX/MEM register outputs, the data memory and the hazard logic.

---
 rtl/dmem_access_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the MEM stage, shared with a debug port.
// Handles req/ack sequencing, arbitration, timeout and the pipeline stall.
module dmem_access_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_mem_read,
    input  logic              pipe_mem_write,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    typedef enum logic [2:0] {
        IDLE,
        PIPE_WAIT,
        PIPE_DONE,
        DBG_WAIT,
        DBG_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] starve_cnt;

    logic pipe_pend;
    logic pipe_load;
    logic pipe_both;
    logic starve_hit;
    logic grant_pipe;
    logic grant_dbg;
    logic dbg_denied;
    logic in_wait;
    logic tmo_hit;
    logic finish;

    assign pipe_pend = pipe_mem_read | pipe_mem_write;
    assign pipe_load = pipe_mem_read & ~pipe_mem_write;
    assign pipe_both = pipe_mem_read & pipe_mem_write;

    // Starved debug beats a pending pipe access; otherwise pipe wins.
    assign starve_hit = dbg_req && (starve_cnt >= STARVE_MAX);
    assign grant_dbg  = (state == IDLE) && dbg_req &&
                        (starve_hit || !pipe_pend);
    assign grant_pipe = (state == IDLE) && pipe_pend && !starve_hit;
    assign dbg_denied = grant_pipe && dbg_req;

    assign in_wait = (state == PIPE_WAIT) || (state == DBG_WAIT);
    assign tmo_hit = in_wait && !mem_ack && (tmo_cnt == TMO_LAST);
    assign finish  = in_wait && (mem_ack || tmo_hit);

    // Stall is forced low while reset is held so upstream is released at once.
    assign pipe_stall = pipe_pend && (state != PIPE_DONE) && !reset;
    assign dbg_gnt    = (state == DBG_WAIT) || (state == DBG_DONE);
    assign dbg_done   = (state == DBG_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_dbg) begin
                    state_nx = DBG_WAIT;
                end else if (grant_pipe) begin
                    state_nx = PIPE_WAIT;
                end
            end
            PIPE_WAIT: begin
                if (finish) begin
                    state_nx = PIPE_DONE;
                end
            end
            PIPE_DONE: state_nx = IDLE;
            DBG_WAIT: begin
                if (finish) begin
                    state_nx = DBG_DONE;
                end
            end
            DBG_DONE: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            if (grant_pipe || grant_dbg) begin
                tmo_cnt <= '0;
            end else if (in_wait && !finish) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (grant_dbg) begin
                starve_cnt <= '0;
            end else if (dbg_denied && (starve_cnt < STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pipe_rdata <= '0;
            dbg_rdata  <= '0;
            bus_err    <= 1'b0;
        end else begin
            if (grant_pipe) begin
                mem_req   <= 1'b1;
                mem_we    <= pipe_mem_write;
                mem_addr  <= pipe_addr;
                mem_wdata <= pipe_wdata;
            end else if (grant_dbg) begin
                mem_req   <= 1'b1;
                mem_we    <= dbg_we;
                mem_addr  <= dbg_addr;
                mem_wdata <= dbg_wdata;
            end else if (finish) begin
                mem_req <= 1'b0;
            end

            if (tmo_hit) begin
                bus_err <= 1'b1;
            end

            if (state == PIPE_WAIT) begin
                if (mem_ack) begin
                    if (pipe_load) begin
                        pipe_rdata <= mem_rdata;
                    end else if (pipe_both) begin
                        pipe_rdata <= '0;
                    end
                end else if (tmo_hit) begin
                    pipe_rdata <= '0;
                end
            end

            if (state == DBG_WAIT) begin
                if (mem_ack && !mem_we) begin
                    dbg_rdata <= mem_rdata;
                end else if (tmo_hit) begin
                    dbg_rdata <= '0;
                end
            end
        end
    end

endmodule
